// File: rtl/cam_seq_pkg.sv
// cam_seq_pkg: state encoding and default timing constants for the camera power sequencer
package cam_seq_pkg;
    localparam int CNT_W           = 23;
    localparam int DEF_PWDN_CYC    = 25000;
    localparam int DEF_RST_CYC     = 25000;
    localparam int DEF_BOOT_CYC    = 500000;
    localparam int DEF_CFG_TIMEOUT = 2500000;
    localparam int DEF_STAGE_CYC   = 1024;
    localparam int DEF_MAX_RETRY   = 2;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PWDN_HOLD = 3'd1,
        S_RST_HOLD  = 3'd2,
        S_BOOT_WAIT = 3'd3,
        S_CFG_START = 3'd4,
        S_CFG_WAIT  = 3'd5,
        S_STAGE     = 3'd6,
        S_RUN       = 3'd7
    } state_t;
endpackage

// File: rtl/seq_timer.sv
// seq_timer: free-running cycle counter with synchronous clear and terminal compare
//   clk  - clock
//   rst  - synchronous active-high reset
//   clr  - clears the count on the next edge
//   term - terminal value to compare against
//   cnt  - current count
//   hit  - high while cnt equals term
module seq_timer
    import cam_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [CNT_W-1:0] term,
    output logic [CNT_W-1:0] cnt,
    output logic             hit
);
    always_ff @(posedge clk)
        cnt <= (rst || clr) ? '0 : cnt + CNT_W'(1);

    assign hit = cnt == term;
endmodule

// File: rtl/cam_power_seq.sv
// cam_power_seq: camera power-up sequencer (PWDN/RESET timing, SCCB config with retry, staged pipeline resets)
//   iCLK, iRST         - clock, synchronous active-high reset
//   iEN                - level request to bring the camera path up
//   iCFG_DONE/iCFG_ERR - one-cycle configurator completion / error strobes
//   oCAM_PWDN/oCAM_RSTn- sensor power-down and reset pins
//   oCFG_START         - one-cycle configurator start pulse
//   oRST_0..2          - staged pipeline resets (0 = held)
//   oREADY, oFAULT     - path up / retries exhausted
//   oSTATE             - current state encoding
module cam_power_seq
    import cam_seq_pkg::*;
#(
    parameter int PWDN_CYC    = DEF_PWDN_CYC,
    parameter int RST_CYC     = DEF_RST_CYC,
    parameter int BOOT_CYC    = DEF_BOOT_CYC,
    parameter int CFG_TIMEOUT = DEF_CFG_TIMEOUT,
    parameter int STAGE_CYC   = DEF_STAGE_CYC,
    parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iEN,
    input  logic       iCFG_DONE,
    input  logic       iCFG_ERR,
    output logic       oCAM_PWDN,
    output logic       oCAM_RSTn,
    output logic       oCFG_START,
    output logic       oRST_0,
    output logic       oRST_1,
    output logic       oRST_2,
    output logic       oREADY,
    output logic       oFAULT,
    output logic [2:0] oSTATE
);
    localparam logic [CNT_W-1:0] T_PWDN  = CNT_W'(PWDN_CYC - 1);
    localparam logic [CNT_W-1:0] T_RST   = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] T_BOOT  = CNT_W'(BOOT_CYC - 1);
    localparam logic [CNT_W-1:0] T_CFG   = CNT_W'(CFG_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] T_R0    = CNT_W'(STAGE_CYC - 1);
    localparam logic [CNT_W-1:0] T_R1    = CNT_W'(2 * STAGE_CYC - 1);
    localparam logic [CNT_W-1:0] T_R2    = CNT_W'(3 * STAGE_CYC - 1);
    // STAGE holds one extra cycle after the last release so oREADY follows oRST_2
    localparam logic [CNT_W-1:0] T_STAGE = CNT_W'(3 * STAGE_CYC);

    state_t           state, nxt;
    logic [1:0]       retry;
    logic [CNT_W-1:0] cnt, term;
    logic             hit, fail, stg;

    seq_timer u_timer (
        .clk  (iCLK),
        .rst  (iRST),
        .clr  (nxt != state),
        .term (term),
        .cnt  (cnt),
        .hit  (hit)
    );

    always_comb begin
        term = state == S_PWDN_HOLD ? T_PWDN :
               state == S_RST_HOLD  ? T_RST  :
               state == S_BOOT_WAIT ? T_BOOT :
               state == S_CFG_WAIT  ? T_CFG  : T_STAGE;
        // error or timeout outranks a simultaneous done
        fail = state == S_CFG_WAIT && (iCFG_ERR || hit);
        nxt = state;
        if (state != S_IDLE && !iEN)
            nxt = S_IDLE;
        else
            case (state)
                S_IDLE:      nxt = (iEN && !oFAULT) ? S_PWDN_HOLD : S_IDLE;
                S_PWDN_HOLD: nxt = hit ? S_RST_HOLD : state;
                S_RST_HOLD:  nxt = hit ? S_BOOT_WAIT : state;
                S_BOOT_WAIT: nxt = hit ? S_CFG_START : state;
                S_CFG_START: nxt = S_CFG_WAIT;
                S_CFG_WAIT:  nxt = fail ? (32'(retry) < MAX_RETRY ? S_PWDN_HOLD : S_IDLE) :
                                   iCFG_DONE ? S_STAGE : state;
                S_STAGE:     nxt = hit ? S_RUN : state;
                default:     nxt = state;
            endcase
        stg = state == S_STAGE && nxt == S_STAGE;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state      <= S_IDLE;
            retry      <= '0;
            oCAM_PWDN  <= 1'b1;
            oCAM_RSTn  <= 1'b0;
            oCFG_START <= 1'b0;
            oRST_0     <= 1'b0;
            oRST_1     <= 1'b0;
            oRST_2     <= 1'b0;
            oREADY     <= 1'b0;
            oFAULT     <= 1'b0;
            oSTATE     <= S_IDLE;
        end else begin
            state      <= nxt;
            retry      <= nxt == S_IDLE ? 2'd0 : (fail ? retry + 2'd1 : retry);
            oCAM_PWDN  <= nxt == S_IDLE || nxt == S_PWDN_HOLD;
            oCAM_RSTn  <= nxt != S_IDLE && nxt != S_PWDN_HOLD && nxt != S_RST_HOLD;
            oCFG_START <= nxt == S_CFG_START;
            // releases are sticky within STAGE and forced high in RUN
            oRST_0     <= nxt == S_RUN || (stg && (oRST_0 || cnt == T_R0));
            oRST_1     <= nxt == S_RUN || (stg && (oRST_1 || cnt == T_R1));
            oRST_2     <= nxt == S_RUN || (stg && (oRST_2 || cnt == T_R2));
            oREADY     <= nxt == S_RUN;
            // fault latches on an exhausted retry and holds until iEN drops
            oFAULT     <= iEN && (oFAULT || (fail && nxt == S_IDLE));
            oSTATE     <= nxt;
        end
    end
endmodule

// File: tb/tb_cam_power_seq.sv
// tb_cam_power_seq: directed self-checking bench for cam_power_seq with short timing parameters
module tb_cam_power_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        done = 1'b0;
    logic        err = 1'b0;
    logic        pwdn, rstn, cfg_start, r0, r1, r2, ready, fault;
    logic [2:0]  st;
    logic [10:0] obs, exp_v;
    int          checks = 0;
    int          fails = 0;

    // {state, pwdn, rstn, cfg_start, rst0, rst1, rst2, ready, fault}
    localparam logic [10:0] IDLE_V  = 11'b000_1_0_0_000_0_0;
    localparam logic [10:0] FAULT_V = 11'b000_1_0_0_000_0_1;

    cam_power_seq #(
        .PWDN_CYC(4), .RST_CYC(4), .BOOT_CYC(8), .CFG_TIMEOUT(16), .STAGE_CYC(4), .MAX_RETRY(1)
    ) dut (
        .iCLK(clk), .iRST(rst), .iEN(en), .iCFG_DONE(done), .iCFG_ERR(err),
        .oCAM_PWDN(pwdn), .oCAM_RSTn(rstn), .oCFG_START(cfg_start),
        .oRST_0(r0), .oRST_1(r1), .oRST_2(r2), .oREADY(ready), .oFAULT(fault), .oSTATE(st)
    );

    always #5 clk = ~clk;
    assign obs = {st, pwdn, rstn, cfg_start, r0, r1, r2, ready, fault};

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; done = 1'b1; err = 1'b1;
        step(2);
        checks++; if (obs !== IDLE_V) begin fails++; $display("FAIL reset_dominates: got %b exp %b", obs, IDLE_V); end
        rst = 1'b0; en = 1'b0; done = 1'b0; err = 1'b0;
        step(1);
        checks++; if (obs !== IDLE_V) begin fails++; $display("FAIL reset_idle: got %b exp %b", obs, IDLE_V); end
    endtask

    task automatic test_nominal;
        logic [2:0] s;
        en = 1'b1;
        for (int n = 1; n <= 36; n++) begin
            step(1);
            s = n <= 4 ? 3'd1 : n <= 8 ? 3'd2 : n <= 16 ? 3'd3 : n == 17 ? 3'd4 :
                n <= 20 ? 3'd5 : n <= 33 ? 3'd6 : 3'd7;
            exp_v = {s, n <= 4, n >= 9, n == 17, n >= 25, n >= 29, n >= 33, n >= 34, 1'b0};
            checks++; if (obs !== exp_v) begin fails++; $display("FAIL nominal_c%0d: got %b exp %b", n, obs, exp_v); end
            done = n == 20;
        end
        en = 1'b0;
        step(1);
        checks++; if (obs !== IDLE_V) begin fails++; $display("FAIL nominal_disable: got %b exp %b", obs, IDLE_V); end
    endtask

    task automatic test_retry;
        done = 1'b1; err = 1'b1;
        step(1);
        checks++; if (obs !== IDLE_V) begin fails++; $display("FAIL ignore_in_idle: got %b exp %b", obs, IDLE_V); end
        done = 1'b0; err = 1'b0; en = 1'b1;
        step(17);
        checks++; if (obs !== 11'b100_0_1_1_000_0_0) begin fails++; $display("FAIL retry_start1: got %b exp %b", obs, 11'b100_0_1_1_000_0_0); end
        step(1);
        err = 1'b1;
        step(1);
        err = 1'b0;
        checks++; if (obs !== 11'b001_1_0_0_000_0_0) begin fails++; $display("FAIL retry_err_pwdn: got %b exp %b", obs, 11'b001_1_0_0_000_0_0); end
        step(16);
        checks++; if (obs !== 11'b100_0_1_1_000_0_0) begin fails++; $display("FAIL retry_start2: got %b exp %b", obs, 11'b100_0_1_1_000_0_0); end
        step(1);
        done = 1'b1;
        step(1);
        done = 1'b0;
        checks++; if (obs !== 11'b110_0_1_0_000_0_0) begin fails++; $display("FAIL retry_stage: got %b exp %b", obs, 11'b110_0_1_0_000_0_0); end
        step(12);
        checks++; if (obs !== 11'b110_0_1_0_111_0_0) begin fails++; $display("FAIL retry_stage_end: got %b exp %b", obs, 11'b110_0_1_0_111_0_0); end
        step(1);
        checks++; if (obs !== 11'b111_0_1_0_111_1_0) begin fails++; $display("FAIL retry_run: got %b exp %b", obs, 11'b111_0_1_0_111_1_0); end
        en = 1'b0;
        step(1);
    endtask

    task automatic test_timeout_fault;
        en = 1'b1;
        step(33);
        checks++; if (st !== 3'd5) begin fails++; $display("FAIL timeout_wait1_last: got %0d exp 5", st); end
        step(1);
        checks++; if (obs !== 11'b001_1_0_0_000_0_0) begin fails++; $display("FAIL timeout_retry: got %b exp %b", obs, 11'b001_1_0_0_000_0_0); end
        step(32);
        checks++; if (st !== 3'd5) begin fails++; $display("FAIL timeout_wait2_last: got %0d exp 5", st); end
        step(1);
        checks++; if (obs !== FAULT_V) begin fails++; $display("FAIL fault_set: got %b exp %b", obs, FAULT_V); end
        step(5);
        checks++; if (obs !== FAULT_V) begin fails++; $display("FAIL fault_sticky: got %b exp %b", obs, FAULT_V); end
        en = 1'b0;
        step(1);
        checks++; if (obs !== IDLE_V) begin fails++; $display("FAIL fault_clear: got %b exp %b", obs, IDLE_V); end
        en = 1'b1;
        step(1);
        checks++; if (obs !== 11'b001_1_0_0_000_0_0) begin fails++; $display("FAIL fault_restart: got %b exp %b", obs, 11'b001_1_0_0_000_0_0); end
        en = 1'b0;
        step(1);
    endtask

    task automatic test_err_done_same;
        en = 1'b1;
        step(18);
        done = 1'b1; err = 1'b1;
        step(1);
        done = 1'b0; err = 1'b0;
        checks++; if (st !== 3'd1) begin fails++; $display("FAIL err_wins: got %0d exp 1", st); end
        en = 1'b0;
        step(1);
        checks++; if (obs !== IDLE_V) begin fails++; $display("FAIL err_wins_abort: got %b exp %b", obs, IDLE_V); end
    endtask

    task automatic test_abort_stage;
        en = 1'b1;
        step(18);
        done = 1'b1;
        step(1);
        done = 1'b0;
        step(4);
        checks++; if (obs !== 11'b110_0_1_0_100_0_0) begin fails++; $display("FAIL abort_pre: got %b exp %b", obs, 11'b110_0_1_0_100_0_0); end
        en = 1'b0;
        step(1);
        checks++; if (obs !== IDLE_V) begin fails++; $display("FAIL abort_stage: got %b exp %b", obs, IDLE_V); end
    endtask

    task automatic test_rst_in_run;
        en = 1'b1;
        step(18);
        done = 1'b1;
        step(1);
        done = 1'b0;
        step(13);
        checks++; if (obs !== 11'b111_0_1_0_111_1_0) begin fails++; $display("FAIL run_before_rst: got %b exp %b", obs, 11'b111_0_1_0_111_1_0); end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checks++; if (obs !== IDLE_V) begin fails++; $display("FAIL rst_in_run: got %b exp %b", obs, IDLE_V); end
        step(1);
        checks++; if (obs !== 11'b001_1_0_0_000_0_0) begin fails++; $display("FAIL rst_restart: got %b exp %b", obs, 11'b001_1_0_0_000_0_0); end
        en = 1'b0;
        step(1);
    endtask

    initial begin
        test_reset;
        test_nominal;
        test_retry;
        test_timeout_fault;
        test_err_done_same;
        test_abort_stage;
        test_rst_in_run;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
